// File: rtl/confused_pkg.sv
// Shared types and constants for the divider issue sequencer
// and the multicycle divider it feeds.
package confused_pkg;

  localparam int RD_W         = 4;
  localparam int OPCTRL_START = 1;
  localparam int OPCTRL_SEL   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } div_issue_state_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Decode request, divider and writeback bundle seen by
// the divider issue sequencer.
interface div_issue_ctrl_if #(
  parameter int W    = 16,
  parameter int RD_W = confused_pkg::RD_W
);

  logic            req_valid;
  logic            req_ready;
  logic [W-1:0]    req_dividend;
  logic [W-1:0]    req_divisor;
  logic            req_is_mod;
  logic [RD_W-1:0] req_rd;

  logic [W-1:0]    div_dividend;
  logic [W-1:0]    div_divisor;
  logic [1:0]      div_opctrl;
  logic            div_busy;
  logic [W-1:0]    div_out;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [RD_W-1:0] rsp_rd;
  logic            rsp_dz;

  modport slave (
    input  req_valid,
    input  req_dividend,
    input  req_divisor,
    input  req_is_mod,
    input  req_rd,
    output req_ready,
    output div_dividend,
    output div_divisor,
    output div_opctrl,
    input  div_busy,
    input  div_out,
    output rsp_valid,
    input  rsp_ready,
    output rsp_data,
    output rsp_rd,
    output rsp_dz
  );

  modport master (
    output req_valid,
    output req_dividend,
    output req_divisor,
    output req_is_mod,
    output req_rd,
    input  req_ready,
    input  div_dividend,
    input  div_divisor,
    input  div_opctrl,
    output div_busy,
    output div_out,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_data,
    input  rsp_rd,
    input  rsp_dz
  );

endinterface

// File: rtl/div_issue_ctrl.sv
// Execute-stage sequencer in front of the multicycle divider:
// issue, wait, capture, respond, drain on flush, timeout on hang.
module div_issue_ctrl
  import confused_pkg::*;
#(
  parameter int W           = 16,
  parameter int TIMEOUT_CYC = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  output logic         timeout_err,
  output logic         stall,
  div_issue_ctrl_if.slave io
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYC);

  div_issue_state_t state_q, state_d;

  logic [W-1:0]     dividend_q, dividend_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic             is_mod_q, is_mod_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [W-1:0]     data_q, data_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;

  logic             req_ready;
  logic             accept;
  logic             start;
  logic [CNT_W-1:0] cnt_inc;

  assign req_ready = (state_q == ST_IDLE) & ~flush;
  assign accept    = io.req_valid & req_ready;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q
                                        : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    is_mod_d   = is_mod_q;
    rd_d       = rd_q;
    data_d     = data_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    start      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dividend_d = io.req_dividend;
          divisor_d  = io.req_divisor;
          is_mod_d   = io.req_is_mod;
          rd_d       = io.req_rd;
          if (io.req_divisor != '0) begin
            dz_d    = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            data_d  = '0;
            dz_d    = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        start   = 1'b1;
        cnt_d   = '0;
        state_d = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (!io.div_busy) begin
          data_d  = io.div_out;
          state_d = ST_RESP;
        end else if (cnt_inc == CNT_MAX) begin
          data_d  = '0;
          terr_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush || io.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Divider cannot be aborted; swallow its result
        cnt_d = cnt_inc;
        if (!io.div_busy) begin
          state_d = ST_IDLE;
        end else if (cnt_inc == CNT_MAX) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      is_mod_q   <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      is_mod_q   <= is_mod_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
    end
  end

  // Select is held through capture: the divider mux reads it late
  always_comb begin
    io.div_opctrl               = '0;
    io.div_opctrl[OPCTRL_START] = start;
    io.div_opctrl[OPCTRL_SEL]   = is_mod_q;
  end

  assign io.req_ready    = req_ready;
  assign io.div_dividend = dividend_q;
  assign io.div_divisor  = divisor_q;
  assign io.rsp_valid    = (state_q == ST_RESP);
  assign io.rsp_data     = data_q;
  assign io.rsp_rd       = rd_q;
  assign io.rsp_dz       = dz_q;
  assign timeout_err     = terr_q;
  assign stall           = (state_q != ST_IDLE);

endmodule
